// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Shared operation and state encodings for the calculator sequencer.
// Rev    : 1.0
// ============================================================================
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_datapath.sv
`default_nettype none
// ============================================================================
// Module : calc_sequencer_datapath
// Brief  : Combinational 4-bit calculator core (add/sub/mul, 8-bit result).
// Rev    : 1.0
// ============================================================================
module calc_sequencer_datapath
  import calc_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] y_o
);

  logic [7:0] w_a;
  logic [7:0] w_b;

  assign w_a = {4'b0000, a_i};
  assign w_b = {4'b0000, b_i};

  // Any op with bit1 set multiplies; subtraction wraps modulo 256.
  always_comb begin
    y_o = 8'h00;
    if (op_i[1]) begin
      y_o = w_a * w_b;
    end else if (op_i == OP_SUB) begin
      y_o = w_a - w_b;
    end else begin
      y_o = w_a + w_b;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : calc_sequencer
// Brief  : Latches a calculator request, settles the datapath, captures the
//          result and hands it over with a valid/ack handshake.
// Rev    : 1.0
// ============================================================================
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int EXEC_CYCLES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [3:0]         a_in,
  input  logic [3:0]         b_in,
  input  logic               chain,
  input  logic               ack,
  output logic               busy,
  output logic               result_valid,
  output logic [7:0]         result,
  output logic [COUNT_W-1:0] op_count
);

  localparam logic [3:0] C_CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [3:0]         a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         result_q, result_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [7:0]         w_dp_y;

  calc_sequencer_datapath u_datapath (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (w_dp_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      cnt_q    <= 4'h0;
      result_q <= 8'h00;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = valid_q;
    count_d  = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          b_d     = b_in;
          a_d     = chain ? result_q[3:0] : a_in;
          cnt_d   = C_CNT_LOAD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != 4'h0) begin
          cnt_d = cnt_q - 4'h1;
        end else begin
          result_d = w_dp_y;
          valid_d  = 1'b1;
          count_d  = count_q + COUNT_W'(1);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Result is kept after ack so the next request can chain from it.
        if (ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = valid_q;
  assign result       = result_q;
  assign op_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_sequencer
// Brief  : Directed and random checks of calc_sequencer against a
//          transaction-level model (default and EXEC_CYCLES=1/COUNT_W=2).
// Rev    : 1.0
// ============================================================================
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [2];
  logic [1:0] op_s    [2];
  logic [3:0] a_s     [2];
  logic [3:0] b_s     [2];
  logic       chain_s [2];
  logic       ack_s   [2];
  logic       busy_s  [2];
  logic       valid_s [2];
  logic [7:0] res_s   [2];
  logic [7:0] cnt_s   [2];
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_res [2];
  int         exp_cnt [2];

  always #5 clk = ~clk;

  calc_sequencer #(.EXEC_CYCLES(2), .COUNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]), .a_in(a_s[0]),
    .b_in(b_s[0]), .chain(chain_s[0]), .ack(ack_s[0]), .busy(busy_s[0]),
    .result_valid(valid_s[0]), .result(res_s[0]), .op_count(cnt_s[0])
  );

  calc_sequencer #(.EXEC_CYCLES(1), .COUNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]), .a_in(a_s[1]),
    .b_in(b_s[1]), .chain(chain_s[1]), .ack(ack_s[1]), .busy(busy_s[1]),
    .result_valid(valid_s[1]), .result(res_s[1]), .op_count(cnt2)
  );

  assign cnt_s[1] = {6'b000000, cnt2};

  function automatic logic [7:0] ref_calc(logic [1:0] o, logic [3:0] a, logic [3:0] b);
    int r;
    if (o[1])        r = int'(a) * int'(b);
    else if (o == 1) r = int'(a) - int'(b);
    else             r = int'(a) + int'(b);
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int w, input string tag);
    chk({tag, "_busy"},  {31'd0, busy_s[w]},  32'd0);
    chk({tag, "_valid"}, {31'd0, valid_s[w]}, 32'd0);
    chk({tag, "_res"},   {24'd0, res_s[w]},   {24'd0, exp_res[w]});
    chk({tag, "_cnt"},   {24'd0, cnt_s[w]},   exp_cnt[w]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      exp_res[w] = 8'h00;
      exp_cnt[w] = 0;
      chk_idle(w, "reset");
    end
  endtask

  // One full transaction: accept, settle (optionally scrambling inputs and
  // pulsing start), capture, hold one cycle unacknowledged, then ack.
  task automatic run_op(input int w, input logic [1:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic ch, input bit tog, input bit extra);
    int         e   = (w == 0) ? 2 : 1;
    int         mod = (w == 0) ? 256 : 4;
    logic [3:0] ea  = ch ? exp_res[w][3:0] : a;
    logic [7:0] er  = ref_calc(o, ea, b);
    start_s[w] = 1'b1; op_s[w] = o; a_s[w] = a; b_s[w] = b; chain_s[w] = ch;
    tick();
    start_s[w] = extra;
    chk("accept_busy", {31'd0, busy_s[w]}, 32'd1);
    for (int k = 1; k <= e; k++) begin
      if (tog) begin
        a_s[w] = 4'($urandom); b_s[w] = 4'($urandom);
        op_s[w] = 2'($urandom); chain_s[w] = 1'($urandom);
      end
      tick();
      chk((k < e) ? "settle_valid" : "capture_valid", {31'd0, valid_s[w]},
          (k < e) ? 32'd0 : 32'd1);
    end
    exp_res[w] = er;
    exp_cnt[w] = (exp_cnt[w] + 1) % mod;
    chk("done_res",  {24'd0, res_s[w]}, {24'd0, er});
    chk("done_cnt",  {24'd0, cnt_s[w]}, exp_cnt[w]);
    chk("done_busy", {31'd0, busy_s[w]}, 32'd1);
    start_s[w] = 1'b0;
    tick();
    chk("hold_valid", {31'd0, valid_s[w]}, 32'd1);
    chk("hold_res",   {24'd0, res_s[w]}, {24'd0, er});
    ack_s[w] = 1'b1; start_s[w] = extra;
    tick();
    ack_s[w] = 1'b0; start_s[w] = 1'b0;
    chk_idle(w, "ack");
    tick();
    chk_idle(w, "post_ack");
  endtask

  initial begin
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      start_s[w] = 1'b0; op_s[w] = 2'b00; a_s[w] = 4'h0; b_s[w] = 4'h0;
      chain_s[w] = 1'b0; ack_s[w] = 1'b0;
      exp_res[w] = 8'h00; exp_cnt[w] = 0;
    end
    tick();
    do_reset();

    // Idle with stray ack: nothing may change.
    ack_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle(0, "idle");
    end
    ack_s[0] = 1'b0;

    run_op(0, 2'b00, 4'd3,  4'd4,  1'b0, 1'b0, 1'b0);
    run_op(0, 2'b10, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0);
    run_op(0, 2'b10, 4'd2,  4'd3,  1'b0, 1'b0, 1'b0);
    run_op(0, 2'b10, 4'd9,  4'd2,  1'b1, 1'b0, 1'b0);
    chk("chain_mul", {24'd0, res_s[0]}, 32'h0C);
    run_op(0, 2'b01, 4'd3,  4'd5,  1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      run_op(0, 2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
    end

    // Reset while in DONE.
    start_s[0] = 1'b1; op_s[0] = 2'b00; a_s[0] = 4'd1; b_s[0] = 4'd1; chain_s[0] = 1'b0;
    tick();
    start_s[0] = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, valid_s[0]}, 32'd1);
    do_reset();

    // Chain right after reset uses A=0.
    run_op(0, 2'b00, 4'd9, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("chain_after_rst", {24'd0, res_s[0]}, 32'h05);

    // Reset mid-EXEC abandons the operation.
    start_s[0] = 1'b1; op_s[0] = 2'b10; a_s[0] = 4'd7; b_s[0] = 4'd7;
    tick();
    start_s[0] = 1'b0;
    do_reset();
    tick();
    chk_idle(0, "abandon");

    // Short-latency, narrow-counter instance: counts wrap 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      run_op(1, 2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0);
      chk("wrap_seq", {24'd0, cnt_s[1]}, (i + 1) % 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Registered front-end controller for the 4-bit calculator datapath (add/sub/mul, 8-bit result).
- Accepts an operation request on a start pulse and latches the operands.
- Holds the datapath inputs stable for a programmable settling window, then captures the result into a register.
- Presents the result with valid/ack handshake.
- Supports chaining: the previous result's low nibble becomes operand A.
- Sits between the button/switch input logic and the display driver.

Parameters:
- EXEC_CYCLES, 2, settling cycles with operands applied before capture; legal range 1..15.
- COUNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation: 00 add, 01 sub, 1x multiply.
- a_in  input  4  operand A; ignored when chain=1.
- b_in  input  4  operand B.
- chain  input  1  when 1 at accept, A = result[3:0] instead of a_in.
- ack  input  1  consumer acknowledge; sampled only in DONE.
- busy  output  1  high whenever state != IDLE.
- result_valid  output  1  result register holds an unacknowledged value.
- result  output  8  captured datapath output.
- op_count  output  COUNT_W  number of completed operations, wraps modulo 2^COUNT_W.

Clock and reset (decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset, on the rising edge with rst=1:
  - state=IDLE, busy=0, result_valid=0, result=8'h00, op_count=0.
  - Latched op/A/B=0; settle counter=0.
  - rst has priority over all other inputs in every state.
- FSM states: IDLE, EXEC, DONE.
- IDLE, start=1:
  - Latch op_r<=op, b_r<=b_in, a_r<=(chain ? result[3:0] : a_in).
  - Load cnt<=EXEC_CYCLES-1; go to EXEC.
  - start=0: remain in IDLE.
- EXEC:
  - Datapath is driven only from op_r/a_r/b_r. Changes on op/a_in/b_in/chain have no effect.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: result<=datapath out, result_valid<=1, op_count<=op_count+1; go to DONE.
- DONE:
  - result and result_valid are held stable until ack=1.
  - On ack=1: result_valid<=0, go to IDLE. result is retained, not cleared, so it can be chained.
- Latency: with start sampled at edge N, result_valid is first visible after edge N+EXEC_CYCLES. busy is visible from after edge N through the edge that samples ack.
- Throughput: one operation per EXEC_CYCLES+2 cycles minimum (ack held high).
- Ignored inputs:
  - start in EXEC or DONE is dropped, not queued.
  - start and ack high together in DONE: the ack is taken, the start is dropped. The next start is accepted in IDLE, one cycle later at the earliest.
  - ack outside DONE has no effect.
- chain=1 right after reset uses A=0.
- Reset mid-EXEC: the operation is abandoned and op_count is not incremented.
- Arithmetic: result equals the datapath's 8-bit output captured verbatim. The controller performs no arithmetic other than op_count.

Decomposition:
- Shared package calc_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10 (bit1 set = multiply);
  - state encodings for IDLE/EXEC/DONE.
- One sub-module, instantiated once: the existing calculator datapath, driven from op_r/a_r/b_r.
- FSM, settle counter, result register and op_count live in calc_sequencer.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, result_valid=0, result=8'h00, op_count=0. Assert rst while in DONE -> all of these return to reset values on the next edge.
- start, op=00, a_in=3, b_in=4, EXEC_CYCLES=2 -> result_valid rises 2 edges after the accepting edge, result=8'h07, op_count=1. ack -> result_valid=0, busy=0 next cycle, result still 8'h07.
- start, op=10, a_in=15, b_in=15; toggle a_in/b_in every cycle during EXEC -> result=8'hE1.
- op=10, a=2, b=3 -> 8'h06, ack; then start with chain=1, op=10, b_in=2, a_in=9 -> result=8'h0C.
- start pulsed during EXEC and again in DONE together with ack -> exactly one operation is completed, op_count increments by 1, state is IDLE afterwards.
- COUNT_W=2: complete 5 operations -> op_count sequence 1,2,3,0,1. With EXEC_CYCLES=1, result_valid appears 1 edge after the accepting edge.
